// File: rtl/diners_pkg.sv
// Shared types and ring helpers for the dining-philosophers models.
// Fork numbering: seat i sits between fork i and fork i+1 (mod N).
package diners_pkg;

    typedef enum logic [1:0] {
        THINKING,
        HUNGRY,
        EATING,
        READING
    } t_state;

    function automatic int left_fork(input int i);
        return i;
    endfunction

    function automatic int right_fork(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/fork_butler_if.sv
// Request/grant bundle between the philosopher seats and the butler.
// The master drives requests and releases; the slave reports ownership.
interface fork_butler_if #(
    parameter int N = 5
);
    logic [N-1:0]             hungry;
    logic [N-1:0]             done;
    logic [N-1:0]             grant;
    logic [N-1:0]             fork_busy;
    logic [N-1:0]             urgent;
    logic [$clog2(N+1)-1:0]   seated;

    modport master (
        output hungry, done,
        input  grant, fork_busy, urgent, seated
    );

    modport slave (
        input  hungry, done,
        output grant, fork_busy, urgent, seated
    );
endinterface

// File: rtl/fork_butler_seat_ctrl.sv
// Per-seat state machine with a saturating hunger age and urgent flag.
// Age and urgent follow the registered state, one cycle behind it.
module seat_ctrl
    import diners_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   hungry,
    input  logic   done,
    input  logic   win,
    output t_state state,
    output logic   urgent
);
    localparam logic [CW-1:0] AGE_MAX = CW'(MAX_WAIT);

    t_state        state_d;
    logic [CW-1:0] age;

    always_comb begin
        state_d = state;
        unique case (state)
            THINKING: if (hungry) state_d = HUNGRY;
            HUNGRY: begin
                if (!hungry)  state_d = THINKING;
                else if (win) state_d = EATING;
            end
            EATING:   if (done) state_d = THINKING;
            default:  state_d = THINKING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= THINKING;
            age    <= '0;
            urgent <= 1'b0;
        end else begin
            state  <= state_d;
            urgent <= (state == HUNGRY) && (age == AGE_MAX);
            if (state != HUNGRY)    age <= '0;
            else if (age != AGE_MAX) age <= age + 1'b1;
        end
    end

endmodule

// File: rtl/fork_butler.sv
// Central fork arbiter: atomic two-fork grants, N-1 diner cap,
// urgent-first round-robin pick, at most one new diner per cycle.
module fork_butler
    import diners_pkg::*;
#(
    parameter int N        = 5,
    parameter int MAX_WAIT = 15,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input logic          clk,
    input logic          reset,
    fork_butler_if.slave bus
);
    localparam int SW = $clog2(N + 1);
    localparam int PW = $clog2(N);

    t_state          st [N];
    logic [N-1:0]    eating;
    logic [N-1:0]    waiting;
    logic [N-1:0]    urg;
    logic [N-1:0]    busy;
    logic [N-1:0]    elig;
    logic [N-1:0]    hot;
    logic [N-1:0]    win;
    logic [N-1:0]    eat_d;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   pick;
    logic            found;
    logic            granted;
    logic [SW-1:0]   seated_q;
    logic [SW-1:0]   seated_d;

    for (genvar i = 0; i < N; i++) begin : g_seat
        seat_ctrl #(
            .MAX_WAIT (MAX_WAIT),
            .CW       (CW)
        ) u_seat (
            .clk    (clk),
            .reset  (reset),
            .hungry (bus.hungry[i]),
            .done   (bus.done[i]),
            .win    (win[i]),
            .state  (st[i]),
            .urgent (urg[i])
        );
        assign eating[i]  = (st[i] == EATING);
        assign waiting[i] = (st[i] == HUNGRY);
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < N; i++) begin
            busy[left_fork(i)]    = busy[left_fork(i)] | eating[i];
            busy[right_fork(i, N)] = busy[right_fork(i, N)] | eating[i];
        end
    end

    // An urgent seat locks out both neighbours until it has eaten.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = waiting[i]
                && !busy[left_fork(i)]
                && !busy[right_fork(i, N)]
                && (seated_q < SW'(N - 1))
                && (urg[i] || !(urg[(i + N - 1) % N]
                             || urg[right_fork(i, N)]));
        end
    end

    assign hot = |(elig & urg) ? (elig & urg) : elig;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && hot[(int'(rr_ptr) + k) % N]) begin
                found = 1'b1;
                pick  = PW'((int'(rr_ptr) + k) % N);
            end
        end
    end

    always_comb begin
        win = '0;
        if (found) win[pick] = 1'b1;
    end

    // A withdrawal on the winning edge cancels the grant outright.
    assign granted = found && bus.hungry[pick];
    assign eat_d   = (eating & ~bus.done) | (win & bus.hungry);

    always_comb begin
        seated_d = '0;
        for (int i = 0; i < N; i++) begin
            seated_d = seated_d + SW'(eat_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            seated_q <= '0;
        end else begin
            seated_q <= seated_d;
            if (granted) begin
                rr_ptr <= (pick == PW'(N - 1)) ? '0 : pick + 1'b1;
            end
        end
    end

    assign bus.grant     = eating;
    assign bus.fork_busy = busy;
    assign bus.urgent    = urg;
    assign bus.seated    = seated_q;

endmodule
